bin_to_gray_counter: RTL and testbench
======================================

# bin_to_gray_counter

Registered binary up/down counter that also emits the Gray encoding of its count, so every output change is a single-bit change.
- It is the encoding end of the team's Gray-code path: it generates pointers and position codes, and downstream logic or clock-domain crossings decode them back to binary with the existing Gray-to-binary converter.
- Binary and Gray outputs come from the same register stage, so they are never skewed against each other.
- Typical use: read/write pointer source for an async FIFO, or an encoder position emulator.

## Interface
- WIDTH, 4, counter and code width in bits (minimum 2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  advance the count by one step this cycle
- up  in  1  direction: 1 = increment, 0 = decrement; sampled only when en=1
- load  in  1  load `load_bin` into the counter; has priority over `en`
- load_bin  in  WIDTH  binary value to load
- bin  out  WIDTH  registered binary count
- gray  out  WIDTH  registered Gray code, always equal to `bin ^ (bin >> 1)`
- wrap  out  1  one-cycle pulse on a count wrap-around
- step_err  out  1  sticky flag: a load changed the Gray code by more than one bit (see Configuration)

## Operation
- Next binary value is chosen by priority:
  - load=1: load_bin.
  - else en=1, up=1: bin+1, modulo 2^WIDTH.
  - else en=1, up=0: bin−1, modulo 2^WIDTH.
  - else: hold.
- Gray register is loaded with the Gray encoding of the next binary value. It is not derived combinationally from `bin` after the register.
- wrap is registered and set to 1 for exactly one cycle when:
  - counting up from 2^WIDTH−1 to 0, or
  - counting down from 0 to 2^WIDTH−1.
  - A load never sets wrap, even when load_bin produces a numerically wrapped value.
- Count steps (en without load) always change exactly one Gray bit. Loads may change any number of Gray bits.
- `up` is ignored when en=0 or load=1.
- No X propagation is allowed: all outputs are defined from reset onward.

## Timing
- Reset values: bin=0, gray=0, wrap=0, step_err=0. Reset acts immediately on rst_n falling, independent of clk.
- Latency: inputs sampled at rising edge k; bin, gray, wrap and step_err all update at edge k. Outputs are purely registered, with no combinational input-to-output path.
- Throughput: one step per clock when en is held high.
- Reset mid-count: outputs return to 0 asynchronously. Counting resumes from 0 on the first edge after rst_n deasserts with en=1.
- Simultaneous load and en: load wins, no step is taken, wrap=0.
- en=0 and load=0: all registers hold; wrap returns to 0.

## Configuration
- Macro: BIN_TO_GRAY_STEP_CHECK_EN.
- Defined:
  - On each load, the new Gray value is compared with the current gray register.
  - If the popcount of their XOR is greater than 1, step_err is set at the same edge.
  - step_err stays set until reset.
  - A load whose value equals the current count, or differs by one Gray bit, does not set it.
  - Count steps never set it.
- Not defined:
  - The checker logic is absent and step_err is tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset then up-count, WIDTH=4, en=1, up=1:
  - Gray sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,…,1000.
  - bin 15→0 gives gray 1000→0000 and wrap=1 for one cycle.
  - Every step changes exactly one Gray bit.
- Down-count from reset, en=1, up=0: bin 0→15, gray 0000→1000, wrap=1 for one cycle; then bin=14, gray=1001.
- Load priority: bin=3, load=1, load_bin=5, en=1, up=1 → next bin=5, gray=0111, wrap=0.
- Hold and async reset: en=0, load=0 for 5 cycles → bin and gray unchanged. Then assert rst_n=0 between clock edges while bin=9 → bin=0, gray=0, wrap=0 immediately.
- Step check with macro defined:
  - From 0, load 3 (gray 0010, 1 bit changed) → step_err=0.
  - Then load 7 (gray 0100, 2 bits changed) → step_err=1.
  - step_err stays 1 through further counting, until reset.
- Same step-check stimulus without the macro → step_err=0 throughout; bin and gray match the macro-defined run cycle for cycle.

Source files
------------

// File: rtl/bin_to_gray_counter.sv
// -----------------------------------------------------------------------------
// bin_to_gray_counter
//
// Registered binary up/down counter that also emits the Gray code of its count.
// Binary and Gray values come from the same register stage, so they never skew
// against each other. Each count step changes exactly one Gray bit. That makes
// the Gray output usable as an async-FIFO pointer or as an encoder position code.
//
// Parameters:
//   WIDTH        counter / code width in bits (minimum 2)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   en_i         advance the count by one step this cycle
//   up_i         direction (1 = increment, 0 = decrement), used only on a step
//   load_i       load load_bin_i into the counter; has priority over en_i
//   load_bin_i   binary value to load
//   bin_o        registered binary count
//   gray_o       registered Gray code of bin_o
//   wrap_o       one-cycle pulse when a count step wraps around
//   step_err_o   sticky flag: a load moved the Gray code by more than one bit
//
// Optional feature:
//   BIN_TO_GRAY_STEP_CHECK_EN  when defined, loads are checked against the
//                              current Gray code and step_err_o latches on a
//                              multi-bit jump. When undefined, step_err_o is 0.
// -----------------------------------------------------------------------------
module bin_to_gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             up_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_bin_i,
    output logic [WIDTH-1:0] bin_o,
    output logic [WIDTH-1:0] gray_o,
    output logic             wrap_o,
    output logic             step_err_o
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};

    // Binary to reflected Gray code.
    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

`ifdef BIN_TO_GRAY_STEP_CHECK_EN
    // True when more than one bit of v is set (clearing the lowest set bit
    // leaves something behind).
    function automatic logic multi_bit(input logic [WIDTH-1:0] v);
        return (v & (v - ONE)) != ZERO;
    endfunction
`endif

    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic             step_err_q, step_err_d;

    // Next-state selection: load beats step, step beats hold.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load_i) begin
            // A load never signals wrap, even if the value looks wrapped.
            bin_d  = load_bin_i;
            wrap_d = 1'b0;
        end else if (en_i) begin
            if (up_i) begin
                bin_d  = bin_q + ONE;
                wrap_d = (bin_q == MAX);
            end else begin
                bin_d  = bin_q - ONE;
                wrap_d = (bin_q == ZERO);
            end
        end else begin
            bin_d  = bin_q;
            wrap_d = 1'b0;
        end
        // Gray is encoded from the next binary value, so both outputs share
        // the same register stage.
        gray_d = bin2gray(bin_d);
    end

    // Sticky step-error next state.
    always_comb begin
        step_err_d = 1'b0;
`ifdef BIN_TO_GRAY_STEP_CHECK_EN
        if (load_i && multi_bit(gray_d ^ gray_q)) begin
            step_err_d = 1'b1;
        end else begin
            step_err_d = step_err_q;
        end
`else
        step_err_d = 1'b0;
`endif
    end

    // State registers with asynchronous reset to all-zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q      <= ZERO;
            gray_q     <= ZERO;
            wrap_q     <= 1'b0;
            step_err_q <= 1'b0;
        end else begin
            bin_q      <= bin_d;
            gray_q     <= gray_d;
            wrap_q     <= wrap_d;
            step_err_q <= step_err_d;
        end
    end

    assign bin_o      = bin_q;
    assign gray_o     = gray_q;
    assign wrap_o     = wrap_q;
    assign step_err_o = step_err_q;

endmodule

// File: tb/tb_bin_to_gray_counter.sv
module tb_bin_to_gray_counter;

    localparam int W   = 4;
    localparam int MOD = 16;
`ifdef BIN_TO_GRAY_STEP_CHECK_EN
    localparam bit STEP = 1'b1;
`else
    localparam bit STEP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_bin = '0;
    logic [W-1:0] bin_o, gray_o;
    logic         wrap_o, step_err_o;

    int total = 0;
    int bad   = 0;

    // Reference model state (plain integers).
    int m_bin  = 0;
    int m_wrap = 0;
    int m_err  = 0;

    // Expected reflected Gray sequence for counts 0..15.
    int gtab [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    bin_to_gray_counter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (en),
        .up_i       (up),
        .load_i     (load),
        .load_bin_i (load_bin),
        .bin_o      (bin_o),
        .gray_o     (gray_o),
        .wrap_o     (wrap_o),
        .step_err_o (step_err_o)
    );

    always #5 clk = ~clk;

    function automatic int gray_of(input int b);
        return gtab[b % MOD];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".bin"},  {28'd0, bin_o},  m_bin);
        chk({tag, ".gray"}, {28'd0, gray_o}, gray_of(m_bin));
        chk({tag, ".wrap"}, {31'd0, wrap_o}, m_wrap);
        chk({tag, ".err"},  {31'd0, step_err_o}, m_err);
    endtask

    // One clock with the given inputs; model update and full check after the edge.
    task automatic cyc(input string tag, input logic e, input logic u,
                       input logic l, input logic [W-1:0] lb);
        logic [W-1:0] g_before;
        int nb;
        @(negedge clk);
        en = e; up = u; load = l; load_bin = lb;
        g_before = gray_o;
        @(posedge clk);
        if (l) begin
            nb = lb;
            if (STEP && $countones(gray_of(nb) ^ gray_of(m_bin)) > 1) m_err = 1;
            m_wrap = 0;
        end else if (e) begin
            if (u) begin
                m_wrap = (m_bin == MOD - 1);
                nb = (m_bin + 1) % MOD;
            end else begin
                m_wrap = (m_bin == 0);
                nb = (m_bin + MOD - 1) % MOD;
            end
        end else begin
            nb = m_bin;
            m_wrap = 0;
        end
        m_bin = nb;
        #1;
        chk_model(tag);
        if (e && !l) chk({tag, ".onebit"}, $countones(gray_o ^ g_before), 1);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0; load = 1'b0; up = 1'b0;
        #1;
        m_bin = 0; m_wrap = 0; m_err = 0;
        chk_model(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        #2;
        m_bin = 0; m_wrap = 0; m_err = 0;
        chk_model("reset");
        do_reset("reset2");

        // Up-count through a full wrap
        for (int i = 1; i <= 17; i++) begin
            cyc("up", 1'b1, 1'b1, 1'b0, 4'd0);
            chk("up.gtab", {28'd0, gray_o}, gtab[i % MOD]);
            chk("up.wrapk", {31'd0, wrap_o}, (i == 16) ? 1 : 0);
        end

        // Down-count from reset
        do_reset("rst_dn");
        cyc("dn0", 1'b1, 1'b0, 1'b0, 4'd0);
        chk("dn0.const", {27'd0, wrap_o, gray_o}, 32'h18);
        cyc("dn1", 1'b1, 1'b0, 1'b0, 4'd0);
        chk("dn1.const", {27'd0, wrap_o, gray_o}, 32'h09);
        chk("dn1.bin", {28'd0, bin_o}, 14);

        // Load priority over en
        cyc("ld3", 1'b0, 1'b0, 1'b1, 4'd3);
        cyc("ldpri", 1'b1, 1'b1, 1'b1, 4'd5);
        chk("ldpri.const", {23'd0, wrap_o, bin_o, gray_o}, 32'h057);

        // Hold, then asynchronous reset between edges
        cyc("ld9", 1'b0, 1'b0, 1'b1, 4'd9);
        for (int i = 0; i < 5; i++) cyc("hold", 1'b0, 1'b1, 1'b0, 4'd0);
        chk("hold.bin", {28'd0, bin_o}, 9);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        m_bin = 0; m_wrap = 0; m_err = 0;
        chk_model("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cyc("resume", 1'b1, 1'b1, 1'b0, 4'd0);
        chk("resume.bin", {28'd0, bin_o}, 1);

        // Step check sequence
        do_reset("rst_sc");
        cyc("sc_ld3", 1'b0, 1'b0, 1'b1, 4'd3);
        chk("sc_ld3.err", {31'd0, step_err_o}, 0);
        cyc("sc_ld7", 1'b0, 1'b0, 1'b1, 4'd7);
        chk("sc_ld7.err", {31'd0, step_err_o}, STEP ? 1 : 0);
        for (int i = 0; i < 4; i++) cyc("sc_cnt", 1'b1, 1'b1, 1'b0, 4'd0);
        chk("sc_sticky", {31'd0, step_err_o}, STEP ? 1 : 0);
        cyc("sc_same", 1'b0, 1'b0, 1'b1, 4'(m_bin));

        // Randomized traffic against the model
        do_reset("rst_rand");
        for (int i = 0; i < 400; i++) begin
            logic l;
            l = ($urandom_range(0, 9) == 0);
            cyc("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                l, 4'($urandom_range(0, MOD - 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
